// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier (signed/unsigned per op) with valid/ready handshakes.
// Optional macro SEQ_MULT_CYCLES_EN adds the RUN-cycle count output `cycles`.
module seq_mult_hs #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
`ifdef SEQ_MULT_CYCLES_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] cycles
`endif
);

  localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [2*WIDTH-1:0] a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               neg_r;
  logic [2*WIDTH-1:0] product_r;
`ifdef SEQ_MULT_CYCLES_EN
  localparam int CW = $clog2(WIDTH+2);
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
  logic [CW-1:0]      cnt_r;
  logic [CW-1:0]      cycles_r;
  assign cycles = cycles_r;
`endif

  // Unsigned magnitude; the most-negative value maps to 2^(WIDTH-1) correctly.
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x, input logic sm);
    logic [WIDTH-1:0] m;
    if (sm && x[WIDTH-1]) begin
      m = ~x + ONE_W;
    end else begin
      m = x;
    end
    return m;
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign product   = product_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; any illegal encoding returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (b_r == {WIDTH{1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and result load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r       <= {(2*WIDTH){1'b0}};
      b_r       <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      neg_r     <= 1'b0;
      product_r <= {(2*WIDTH){1'b0}};
`ifdef SEQ_MULT_CYCLES_EN
      cnt_r     <= {CW{1'b0}};
      cycles_r  <= {CW{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= {{WIDTH{1'b0}}, mag_f(multiplicand, signed_mode)};
            b_r   <= mag_f(multiplier, signed_mode);
            acc_r <= {(2*WIDTH){1'b0}};
            neg_r <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
`ifdef SEQ_MULT_CYCLES_EN
            cnt_r <= {CW{1'b0}};
`endif
          end
        end
        RUN: begin
          if (b_r != {WIDTH{1'b0}}) begin
            if (b_r[0]) begin
              acc_r <= acc_r + a_r;
            end
            a_r <= {a_r[2*WIDTH-2:0], 1'b0};
            b_r <= {1'b0, b_r[WIDTH-1:1]};
`ifdef SEQ_MULT_CYCLES_EN
            cnt_r <= cnt_r + ONE_C;
`endif
          end else begin
            product_r <= neg_r ? (~acc_r + ONE_P) : acc_r;
`ifdef SEQ_MULT_CYCLES_EN
            cycles_r  <= cnt_r + ONE_C;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
